// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, branch-flush and memory-wait hazard control FSM.
// Define HAZARD_STATS_EN to add the StallCount/FlushCount/WaitCount statistics outputs.
module pipeline_hazard_ctrl #(
    parameter int MEMWAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_Rt,
    input  logic       BranchTaken,
    input  logic       MemBusy,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXBubble,
    output logic       FlushIFID,
    output logic       FlushIDEX,
    output logic       FlushEXMEM,
    output logic       HoldEXMEM,
    output logic [1:0] State,
    output logic       Timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount,
    output logic [15:0] WaitCount
`endif
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LDSTALL = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;
    localparam logic [1:0] FLUSH   = 2'd3;

    logic [1:0] stateReg, nextState;
    logic [3:0] waitCnt, waitNext;
    logic       loadUse, luStall, flush;

    assign loadUse = IDEX_MemRead && IDEX_Rt != 5'd0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
    // IF/ID holds an already-stalled or invalid instruction in LDSTALL and FLUSH
    assign luStall = loadUse && (stateReg == RUN || stateReg == MEMWAIT);
    assign flush   = !Rst && BranchTaken;

    always_comb begin
        nextState  = Rst ? RUN : BranchTaken ? FLUSH : MemBusy ? MEMWAIT : luStall ? LDSTALL : RUN;
        PCWrite    = !Rst && (BranchTaken || (!MemBusy && !luStall));
        IFIDWrite  = !Rst && (BranchTaken || (!MemBusy && !luStall));
        IDEXBubble = Rst || (!BranchTaken && !MemBusy && luStall);
        FlushIFID  = flush;
        FlushIDEX  = flush;
        FlushEXMEM = flush;
        HoldEXMEM  = !Rst && !BranchTaken && MemBusy;
        waitNext   = nextState != MEMWAIT ? 4'd0 : waitCnt == 4'hF ? waitCnt : waitCnt + 4'd1;
    end

    assign State   = stateReg;

    // The wait counter and WaitCount advance on every edge that lands in MEMWAIT
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= RUN;
            waitCnt  <= 4'd0;
            Timeout  <= 1'b0;
        end else begin
            stateReg <= nextState;
            waitCnt  <= waitNext;
            if (nextState == MEMWAIT && int'(waitNext) >= MEMWAIT_MAX)
                Timeout <= 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
            WaitCount  <= 16'd0;
        end else begin
            if (nextState == LDSTALL && ~&StallCount)
                StallCount <= StallCount + 16'd1;
            if (nextState == FLUSH && ~&FlushCount)
                FlushCount <= FlushCount + 16'd1;
            if (nextState == MEMWAIT && ~&WaitCount)
                WaitCount <= WaitCount + 16'd1;
        end
    end
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are Clk and Rst.
REQ-002 The block SHALL have parameter MEMWAIT_MAX, default 15, the maximum number of consecutive MEMWAIT cycles before timeout.
REQ-003 Port Clk, input, 1 bit: rising-edge clock.
REQ-004 Port Rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port IFID_Rs, input, 5 bits: rs field of the instruction in IF/ID.
REQ-006 Port IFID_Rt, input, 5 bits: rt field of the instruction in IF/ID.
REQ-007 Port IDEX_MemRead, input, 1 bit: MemRead held in ID/EX.
REQ-008 Port IDEX_Rt, input, 5 bits: rt destination held in ID/EX.
REQ-009 Port BranchTaken, input, 1 bit: branch resolved taken (EX/MEM Branch AND zero).
REQ-010 Port MemBusy, input, 1 bit: data memory not ready.
REQ-011 Port PCWrite, output, 1 bit: PC update enable.
REQ-012 Port IFIDWrite, output, 1 bit: IF/ID load enable.
REQ-013 Port IDEXBubble, output, 1 bit: force all ID/EX control inputs to 0.
REQ-014 Port FlushIFID, FlushIDEX and FlushEXMEM, outputs, 1 bit each: clear the valid/control bits of that register.
REQ-015 Port HoldEXMEM, output, 1 bit: freeze EX/MEM and MEM/WB.
REQ-016 Port State, output, 2 bits: current FSM state.
REQ-017 Port Timeout, output, 1 bit: sticky MEMWAIT overflow flag.

Function
REQ-018 The FSM SHALL have four states: RUN=0, LDSTALL=1, MEMWAIT=2, FLUSH=3.
REQ-019 Load-use hazard (LU) SHALL be IDEX_MemRead AND IDEX_Rt!=0 AND (IDEX_Rt==IFID_Rs OR IDEX_Rt==IFID_Rt).
REQ-020 Event priority SHALL be: Rst > BranchTaken > MemBusy > LU.
REQ-021 Outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency.
REQ-022 When BranchTaken=1 in any state, the block SHALL assert FlushIFID, FlushIDEX and FlushEXMEM, assert PCWrite=1, and set the next state to FLUSH.
REQ-023 Otherwise, when MemBusy=1: PCWrite=0, IFIDWrite=0, IDEXBubble=0, HoldEXMEM=1, and the next state is MEMWAIT.
REQ-024 Otherwise, when LU=1 in RUN: PCWrite=0, IFIDWrite=0, IDEXBubble=1, and the next state is LDSTALL.
REQ-025 In LDSTALL, LU SHALL be ignored; PCWrite=1, IFIDWrite=1, and the next state is RUN.
REQ-026 In FLUSH, LU SHALL be ignored because IF/ID is invalid; PCWrite=1, IFIDWrite=1, and the next state is RUN.
REQ-027 In MEMWAIT with MemBusy=0, the next state SHALL be RUN; if LU=1 in that cycle, the stall SHALL be applied as in RUN.
REQ-028 Default outputs with no event SHALL be PCWrite=1, IFIDWrite=1, and all other outputs 0.
REQ-029 A 4-bit counter SHALL increment on each MEMWAIT cycle and clear when leaving MEMWAIT.
REQ-030 When the count reaches MEMWAIT_MAX, Timeout SHALL be set; it stays set until Rst and the counter saturates.
REQ-031 BranchTaken asserted during MEMWAIT SHALL win: flush, clear the counter, and go to FLUSH.

Reset
REQ-032 With Rst=1 at a clock edge, State SHALL become RUN and Timeout, the counter and the statistics SHALL become 0.
REQ-033 Rst asserted mid-stall SHALL abort the stall; no residual bubble is issued after reset.
REQ-034 During Rst, outputs SHALL be PCWrite=0, IFIDWrite=0, IDEXBubble=1, and all flush and hold outputs 0.

Configuration
REQ-035 With HAZARD_STATS_EN defined, the block SHALL add 16-bit outputs StallCount (LDSTALL entries), FlushCount (FLUSH entries) and WaitCount (MEMWAIT cycles), each saturating at 0xFFFF and cleared by Rst.
REQ-036 Without HAZARD_STATS_EN, these ports and their logic SHALL be absent and all other behaviour is identical.

Verification
REQ-037 Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> same cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle State=1 and PCWrite=1; then State=0.
REQ-038 $zero case: IDEX_Rt=0 and IFID_Rs=0 with MemRead=1 -> no stall; PCWrite=1.
REQ-039 Branch during stall: LU and BranchTaken=1 in the same cycle -> the three flush outputs =1, IDEXBubble=0, next State=3, then RUN with no stall.
REQ-040 Memory wait: MemBusy=1 for 3 cycles -> HoldEXMEM=1 and PCWrite=0 for 3 cycles, State=2, Timeout=0; then RUN.
REQ-041 Timeout: MemBusy=1 for 20 cycles with MEMWAIT_MAX=15 -> Timeout=1 after the 15th cycle and it holds after MemBusy drops; Rst clears it.
REQ-042 Statistics (HAZARD_STATS_EN): 2 load-use stalls and 1 branch -> StallCount=2 and FlushCount=1; Rst sets both to 0.
